// File: rtl/lsu_mc.sv
// Multi-cycle load/store unit between the EXU request/response port and a
// variable-latency data memory. Handles sizing, byte strobes, misalignment and bus timeout.
module lsu_mc #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_wen,
    input  logic [1:0]          req_size,
    input  logic                req_signed,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    output logic                resp_valid,
    input  logic                resp_ready,
    output logic [DATA_W-1:0]   resp_rdata,
    output logic                resp_err,
    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic                mem_wen,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W/8-1:0] mem_wstrb,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic                mem_resp_valid,
    input  logic [DATA_W-1:0]   mem_resp_rdata
);

    localparam int STRB_W = DATA_W / 8;
    localparam int OFF_W  = $clog2(STRB_W);
    localparam logic [CNT_W-1:0] TO_LAST = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_RESP
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic                r_wen;
    logic [1:0]          r_size;
    logic                r_signed;
    logic [OFF_W-1:0]    r_off;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [STRB_W-1:0]   r_mem_wstrb;
    logic [DATA_W-1:0]   r_mem_wdata;
    logic [DATA_W-1:0]   r_rdata;
    logic                r_err;
    logic [CNT_W-1:0]    r_cnt;

    logic [OFF_W-1:0]    w_off;
    logic                w_misalign;
    logic                w_bad;
    logic                w_timeout;

    function automatic logic [STRB_W-1:0] f_strb(input logic [1:0] size, input logic [OFF_W-1:0] off);
        logic [15:0] m;
        m = (16'd1 << (5'd1 << size)) - 16'd1;
        return STRB_W'(m << off);
    endfunction

    // Pick the addressed lane, then zero/sign-extend from the access width.
    function automatic logic [DATA_W-1:0] f_ext(input logic [DATA_W-1:0] rd, input logic [1:0] size,
                                                input logic sgn, input logic [OFF_W-1:0] off);
        logic [DATA_W-1:0] lane;
        logic [DATA_W-1:0] mask;
        logic              msb;
        int                bits;
        lane = rd >> {off, 3'b000};
        case (size)
            2'd0:    begin bits = 8;      msb = lane[7];  end
            2'd1:    begin bits = 16;     msb = lane[15]; end
            2'd2:    begin bits = 32;     msb = lane[31]; end
            default: begin bits = DATA_W; msb = 1'b0;     end
        endcase
        mask = ~({DATA_W{1'b1}} << bits);
        return (lane & mask) | ({DATA_W{sgn & msb}} & ~mask);
    endfunction

    assign w_off     = req_addr[OFF_W-1:0];
    assign w_timeout = (TIMEOUT != 0) && (r_cnt == TO_LAST);

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        w_misalign = 1'b0;
        case (req_size)
            2'd1:    w_misalign = req_addr[0];
            2'd2:    w_misalign = |req_addr[1:0];
            2'd3:    w_misalign = |req_addr[2:0];
            default: w_misalign = 1'b0;
        endcase
        w_bad = w_misalign || ((req_size == 2'd3) && (DATA_W == 32));
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (req_valid) w_next = w_bad ? S_RESP : S_REQ;
            S_REQ: begin
                if (w_timeout)          w_next = S_RESP;
                else if (mem_req_ready) w_next = S_WAIT;
            end
            // A response on the timeout cycle still completes normally.
            S_WAIT: if (mem_resp_valid || w_timeout) w_next = S_RESP;
            S_RESP: if (resp_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_next;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wen       <= 1'b0;
            r_size      <= '0;
            r_signed    <= 1'b0;
            r_off       <= '0;
            r_mem_addr  <= '0;
            r_mem_wstrb <= '0;
            r_mem_wdata <= '0;
            r_rdata     <= '0;
            r_err       <= 1'b0;
            r_cnt       <= '0;
        end else begin
            r_cnt <= ((r_state == S_REQ) || (r_state == S_WAIT)) ? r_cnt + 1'b1 : '0;
            case (r_state)
                S_IDLE: if (req_valid) begin
                    r_wen       <= req_wen;
                    r_size      <= req_size;
                    r_signed    <= req_signed;
                    r_off       <= w_off;
                    r_mem_addr  <= req_addr & ~ADDR_W'(STRB_W - 1);
                    r_mem_wstrb <= f_strb(req_size, w_off);
                    r_mem_wdata <= req_wdata << {w_off, 3'b000};
                    if (w_bad) begin
                        r_err   <= 1'b1;
                        r_rdata <= '0;
                    end
                end
                S_REQ: if (w_timeout) begin
                    r_err   <= 1'b1;
                    r_rdata <= '0;
                end
                S_WAIT: begin
                    if (mem_resp_valid) begin
                        r_err   <= 1'b0;
                        r_rdata <= r_wen ? '0 : f_ext(mem_resp_rdata, r_size, r_signed, r_off);
                    end else if (w_timeout) begin
                        r_err   <= 1'b1;
                        r_rdata <= '0;
                    end
                end
                S_RESP: if (resp_ready) begin
                    r_err   <= 1'b0;
                    r_rdata <= '0;
                end
                default: ;
            endcase
        end
    end

    assign req_ready     = (r_state == S_IDLE);
    assign resp_valid    = (r_state == S_RESP);
    assign mem_req_valid = (r_state == S_REQ);
    assign resp_rdata    = r_rdata;
    assign resp_err      = r_err;
    assign mem_wen       = r_wen;
    assign mem_addr      = r_mem_addr;
    assign mem_wstrb     = r_mem_wstrb;
    assign mem_wdata     = r_mem_wdata;

endmodule

// File: tb/tb_lsu_mc.sv
// Directed bench for lsu_mc (DATA_W=32, TIMEOUT=8); inputs change and outputs
// are sampled 1 ns after each rising edge.
module tb_lsu_mc;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_wen, req_signed;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_ready, resp_err;
    logic [31:0] resp_rdata;
    logic        mem_req_valid, mem_req_ready, mem_wen;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_rdata;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    lsu_mc #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(8), .CNT_W(8)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wstrb(mem_wstrb),
        .mem_wdata(mem_wdata), .mem_resp_valid(mem_resp_valid),
        .mem_resp_rdata(mem_resp_rdata)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic wen, input logic [1:0] size, input logic sgn,
                         input logic [31:0] addr, input logic [31:0] wdata);
        req_wen    = wen;
        req_size   = size;
        req_signed = sgn;
        req_addr   = addr;
        req_wdata  = wdata;
        req_valid  = 1'b1;
        step();
        req_valid  = 1'b0;
    endtask

    task automatic mem_reply(input logic [31:0] d);
        mem_resp_valid = 1'b1;
        mem_resp_rdata = d;
        step();
        mem_resp_valid = 1'b0;
        mem_resp_rdata = '0;
    endtask

    initial begin
        rst = 1'b0;
        req_valid = 1'b0; req_wen = 1'b0; req_size = '0; req_signed = 1'b0;
        req_addr = '0; req_wdata = '0; resp_ready = 1'b1;
        mem_req_ready = 1'b1; mem_resp_valid = 1'b0; mem_resp_rdata = '0;
        #1;
        check("rst_req_ready", req_ready, 1);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_mem_req_valid", mem_req_valid, 0);
        check("rst_resp_err", resp_err, 0);
        check("rst_resp_rdata", resp_rdata, 0);
        check("rst_mem_wstrb", mem_wstrb, 0);
        step(); step();
        rst = 1'b1;
        step();

        // Word load with latency check: accept c0, mem req c1, resp_valid c3.
        issue(0, 2, 0, 32'h8000_0004, 0);
        check("t1_mem_req_valid_c1", mem_req_valid, 1);
        check("t1_mem_addr", mem_addr, 32'h8000_0004);
        check("t1_wstrb", mem_wstrb, 4'b1111);
        check("t1_mem_wen", mem_wen, 0);
        check("t1_req_ready_busy", req_ready, 0);
        step();
        check("t1_mem_req_valid_c2", mem_req_valid, 0);
        check("t1_resp_valid_c2", resp_valid, 0);
        mem_reply(32'hDEAD_BEEF);
        check("t1_resp_valid_c3", resp_valid, 1);
        check("t1_rdata", resp_rdata, 32'hDEAD_BEEF);
        check("t1_err", resp_err, 0);
        step();
        check("t1_back_idle", req_ready, 1);
        check("t1_resp_dropped", resp_valid, 0);

        // Signed and unsigned byte load from lane 3.
        issue(0, 0, 1, 32'h8000_0003, 0);
        check("t2s_wstrb", mem_wstrb, 4'b1000);
        check("t2s_mem_addr", mem_addr, 32'h8000_0000);
        step();
        mem_reply(32'h8012_3456);
        check("t2s_rdata", resp_rdata, 32'hFFFF_FF80);
        step();
        issue(0, 0, 0, 32'h8000_0003, 0);
        step();
        mem_reply(32'h8012_3456);
        check("t2u_rdata", resp_rdata, 32'h0000_0080);
        step();

        // Half store to upper half-word.
        issue(1, 1, 0, 32'h8000_0002, 32'h0000_ABCD);
        check("t3_wstrb", mem_wstrb, 4'b1100);
        check("t3_wdata", mem_wdata, 32'hABCD_0000);
        check("t3_mem_addr", mem_addr, 32'h8000_0000);
        check("t3_mem_wen", mem_wen, 1);
        step();
        mem_reply(32'hFFFF_FFFF);
        check("t3_resp_valid", resp_valid, 1);
        check("t3_rdata", resp_rdata, 0);
        check("t3_err", resp_err, 0);
        step();

        // Misaligned word and illegal double: straight to an error response.
        issue(0, 2, 0, 32'h8000_0001, 0);
        check("t4a_mem_req_valid", mem_req_valid, 0);
        check("t4a_resp_valid", resp_valid, 1);
        check("t4a_err", resp_err, 1);
        check("t4a_rdata", resp_rdata, 0);
        step();
        check("t4a_err_cleared", resp_err, 0);
        check("t4a_mem_req_idle", mem_req_valid, 0);
        issue(0, 3, 0, 32'h8000_0000, 0);
        check("t4b_mem_req_valid", mem_req_valid, 0);
        check("t4b_err", resp_err, 1);
        check("t4b_rdata", resp_rdata, 0);
        step();

        // mem_req_ready low for 3 cycles; memory fields must hold.
        mem_req_ready = 1'b0;
        issue(1, 1, 0, 32'h8000_0006, 32'h0000_1234);
        for (int i = 0; i < 3; i++) begin
            check("t5a_mem_req_valid", mem_req_valid, 1);
            check("t5a_mem_addr", mem_addr, 32'h8000_0004);
            check("t5a_wstrb", mem_wstrb, 4'b1100);
            check("t5a_wdata", mem_wdata, 32'h1234_0000);
            step();
        end
        check("t5a_still_req", mem_req_valid, 1);
        mem_req_ready = 1'b1;
        step();
        check("t5a_handshake", mem_req_valid, 0);
        mem_reply(0);
        check("t5a_resp_err", resp_err, 0);
        step();

        // resp_ready low for 4 cycles; response fields must hold.
        resp_ready = 1'b0;
        issue(0, 2, 0, 32'h8000_0008, 0);
        step();
        mem_reply(32'h1357_9BDF);
        for (int i = 0; i < 4; i++) begin
            check("t5b_resp_valid", resp_valid, 1);
            check("t5b_rdata", resp_rdata, 32'h1357_9BDF);
            check("t5b_err", resp_err, 0);
            step();
        end
        resp_ready = 1'b1;
        step();
        check("t5b_released", resp_valid, 0);

        // Timeout: error exactly 8 cycles after REQ entry, late response ignored.
        issue(0, 2, 0, 32'h8000_000C, 0);
        for (int i = 1; i < 8; i++) begin
            step();
            check("t5c_no_resp_yet", resp_valid, 0);
        end
        resp_ready = 1'b0;
        step();
        check("t5c_resp_valid", resp_valid, 1);
        check("t5c_err", resp_err, 1);
        check("t5c_rdata", resp_rdata, 0);
        mem_reply(32'hAAAA_AAAA);
        check("t5c_late_err", resp_err, 1);
        check("t5c_late_rdata", resp_rdata, 0);
        resp_ready = 1'b1;
        step();
        check("t5c_idle", req_ready, 1);
        mem_reply(32'h5555_5555);
        check("t5c_late_idle", resp_valid, 0);

        // Completion on the timeout cycle wins.
        issue(0, 2, 0, 32'h8000_0010, 0);
        for (int i = 1; i < 8; i++) step();
        check("t5d_waiting", resp_valid, 0);
        mem_reply(32'h0BAD_F00D);
        check("t5d_resp_valid", resp_valid, 1);
        check("t5d_err", resp_err, 0);
        check("t5d_rdata", resp_rdata, 32'h0BAD_F00D);
        step();

        // Reset during WAIT drops the transaction.
        issue(0, 2, 0, 32'h8000_0014, 0);
        step();
        rst = 1'b0;
        mem_resp_valid = 1'b1;
        mem_resp_rdata = 32'hCAFE_CAFE;
        #1;
        check("t6_req_ready", req_ready, 1);
        check("t6_resp_valid", resp_valid, 0);
        check("t6_mem_req_valid", mem_req_valid, 0);
        step();
        mem_resp_valid = 1'b0;
        mem_resp_rdata = '0;
        rst = 1'b1;
        step();
        check("t6_post_idle", req_ready, 1);
        check("t6_post_resp", resp_valid, 0);
        issue(0, 1, 1, 32'h8000_0002, 0);
        check("t6_wstrb", mem_wstrb, 4'b1100);
        step();
        mem_reply(32'h8001_0000);
        check("t6_resp_valid", resp_valid, 1);
        check("t6_rdata", resp_rdata, 32'hFFFF_8001);
        check("t6_err", resp_err, 0);
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/lsu_mc.md
Name: lsu_mc

Overview:
- Multi-cycle load/store unit; successor to the single-cycle combinational data-memory path.
- Sits between EXU (upstream request/response) and a variable-latency data memory (downstream valid/ready).
- Parametrised in address/data width and timeout.
- Adds:
  - byte/half/word(/double) sizing with sign extension
  - byte strobes
  - misalignment detection
  - bus timeout with error response

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width; legal values 32 or 64
TIMEOUT, 255, max cycles in REQ+WAIT before error; 0 disables timeout
CNT_W, 8, timeout counter width; must satisfy TIMEOUT < 2**CNT_W

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-low
req_valid  in  1  upstream request valid
req_ready  out  1  unit can accept a request
req_wen  in  1  1=store, 0=load
req_size  in  2  0=byte, 1=half, 2=word, 3=double (legal only if DATA_W=64)
req_signed  in  1  sign-extend load result
req_addr  in  ADDR_W  byte address
req_wdata  in  DATA_W  store data, LSB-justified
resp_valid  out  1  response valid
resp_ready  in  1  upstream accepts response
resp_rdata  out  DATA_W  extended load data; 0 for stores and errors
resp_err  out  1  misaligned, illegal size, or timeout
mem_req_valid  out  1  memory request valid
mem_req_ready  in  1  memory accepts request
mem_wen  out  1  store
mem_addr  out  ADDR_W  req_addr with low log2(DATA_W/8) bits cleared
mem_wstrb  out  DATA_W/8  byte enables (loads drive the same strobe pattern)
mem_wdata  out  DATA_W  store data shifted to byte lane
mem_resp_valid  in  1  memory response valid (one cycle)
mem_resp_rdata  in  DATA_W  full-width read data

Behaviour:
- States: IDLE, REQ, WAIT, RESP.
- Reset (rst=0, async): state=IDLE, all outputs 0 except req_ready=1, counter=0, latched request cleared.
- Outputs are registered or pure state decode; no combinational path from req_* to mem_*.

IDLE:
- req_ready=1.
- On req_valid: latch all req_* fields.
- Misaligned (addr mod 2**size != 0) or illegal size: set err, rdata=0, go to RESP. mem_req_valid never asserts.
- Otherwise go to REQ.

REQ:
- mem_req_valid=1.
- mem_addr, mem_wen, mem_wstrb, mem_wdata are stable until handshake.
- Strobe = ((1<<(1<<size))-1) << offset.
- wdata = req_wdata << (8*offset).
- On mem_req_ready go to WAIT.

WAIT:
- On mem_resp_valid, go to RESP.
- Loads: select the lane at offset, then zero- or sign-extend from 8/16/32 bits; full width passes through.
- Stores: rdata=0.
- mem_resp_valid in the same cycle as the REQ handshake is not legal; memory latency is at least 1 cycle.

RESP:
- resp_valid=1; resp_rdata/resp_err held stable until resp_ready.
- On resp_ready: go to IDLE; err cleared.
- Earliest next accept is 1 cycle later (no bypass).

Timeout:
- Counter resets on entry to REQ and increments each cycle in REQ or WAIT.
- When counter==TIMEOUT-1 with no completion: go to RESP, err=1, rdata=0.
- A late mem_resp_valid arriving after this is ignored in all states other than WAIT.
- Completion on the same cycle as the timeout cycle wins over timeout.

Other rules:
- Latency for an aligned load with 1-cycle memory and no backpressure: accept at cycle 0, mem request at 1, response at 2, resp_valid at 3.
- mem_resp_valid outside WAIT is ignored.
- Reset asserted mid-transaction returns to IDLE immediately; the outstanding memory response is dropped.

Test Plan:
1. Word load: addr=0x8000_0004, size=2, mem returns 0xDEADBEEF after 1 cycle -> mem_addr=0x8000_0004, wstrb=4'b1111, resp_rdata=0xDEADBEEF, err=0, resp_valid at cycle 3.
2. Signed byte load: addr=0x8000_0003, signed=1, mem_rdata=0x80123456 -> wstrb=4'b1000, resp_rdata=0xFFFFFF80. Same with signed=0 -> 0x00000080.
3. Half store: addr=0x8000_0002, wdata=0x0000ABCD -> mem_wstrb=4'b1100, mem_wdata=0xABCD0000, mem_addr=0x8000_0000, resp_rdata=0.
4. Misaligned word load at 0x8000_0001, and size=3 with DATA_W=32 -> mem_req_valid stays 0, resp_err=1, resp_rdata=0.
5. Backpressure and timeout:
   - mem_req_ready held low for 3 cycles -> mem fields stable throughout.
   - resp_ready low for 4 cycles -> resp fields stable throughout.
   - With TIMEOUT=8 and no mem_resp_valid -> resp_err=1 exactly 8 cycles after REQ entry; a late mem_resp_valid is ignored.
6. Reset: assert rst=0 during WAIT -> next edge shows state IDLE, req_ready=1, resp_valid=0, mem_req_valid=0. The following transaction completes correctly.
